exec_mul_sequencer: RTL and testbench

- Multi-cycle shift-and-add multiply controller that borrows the execute-stage ALU (ADD op) to form a 16x16 product, low 16 bits only.
- Accepts a request from decode/execute control and stalls the pipeline while it owns the ALU.
- Drives override operands into the execute-stage ALU input muxes and returns the product with a one-cycle done pulse for writeback.

---
 rtl/exec_mul_sequencer.sv | 95 +++++++++
 tb/tb_exec_mul_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/exec_mul_sequencer.sv
// Shift-and-add 16x16 multiply sequencer that borrows the execute-stage ALU adder.
// Keeps the low 16 bits of the product and stalls the pipeline while it owns the ALU.
module exec_mul_sequencer #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cancel,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] alu_result,
   output logic             ovr_en,
   output logic [WIDTH-1:0] ovr_Ain,
   output logic [WIDTH-1:0] ovr_Bin,
   output logic [1:0]       ovr_ALUop,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [CNT_W-1:0] cnt;

   logic             accept;
   logic             in_run;
   logic             last_iter;
   logic [WIDTH-1:0] acc_nxt;

   // rst gating keeps stall low while reset is held, even with start high
   assign accept    = ~rst & (state == IDLE) & start & ~cancel;
   assign in_run    = (state == RUN);
   assign acc_nxt   = mplier[0] ? alu_result : acc;
   assign last_iter = ((mplier >> 1) == '0) || (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  mcand  <= op_a;
                  mplier <= op_b;
                  acc    <= '0;
                  cnt    <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (cancel) begin
                  state <= IDLE;
               end else begin
                  acc    <= acc_nxt;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + CNT_W'(1);
                  if (last_iter) begin
                     result <= acc_nxt;
                     state  <= DONE;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode only registered state, except stall which must react to start
   assign ovr_en    = in_run;
   assign ovr_Ain   = in_run ? acc : '0;
   assign ovr_Bin   = in_run ? mcand : '0;
   assign ovr_ALUop = 2'b00;
   assign busy      = in_run;
   assign stall     = in_run | accept;
   assign done      = (state == DONE);

endmodule

// File: tb/tb_exec_mul_sequencer.sv
// Directed bench for exec_mul_sequencer; models the shared execute ALU as a plain adder.
module tb_exec_mul_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        cancel;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic [15:0] alu_result;
   logic        ovr_en;
   logic [15:0] ovr_Ain;
   logic [15:0] ovr_Bin;
   logic [1:0]  ovr_ALUop;
   logic        stall;
   logic        busy;
   logic        done;
   logic [15:0] result;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // execute-stage ALU, ADD op
   assign alu_result = 16'(ovr_Ain + ovr_Bin);

   exec_mul_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .cancel     (cancel),
      .op_a       (op_a),
      .op_b       (op_b),
      .alu_result (alu_result),
      .ovr_en     (ovr_en),
      .ovr_Ain    (ovr_Ain),
      .ovr_Bin    (ovr_Bin),
      .ovr_ALUop  (ovr_ALUop),
      .stall      (stall),
      .busy       (busy),
      .done       (done),
      .result     (result)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts RUN cycles until busy drops; bounded so a stuck DUT cannot hang the run.
   task automatic count_run(output int n);
      n = 0;
      while (busy && n < 24) begin
         n++;
         tick();
      end
   endtask

   // Single-shot multiply: accept, run, done pulse, back to idle.
   task automatic mul_once(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp, input int exp_n);
      int n;
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      #1;
      check({tag, "_accept_stall"}, 32'(stall), 32'd1);
      tick();
      start = 1'b0;
      count_run(n);
      check({tag, "_run_cycles"}, 32'(n), 32'(exp_n));
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_result"}, 32'(result), 32'(exp));
      check({tag, "_done_stall"}, 32'(stall), 32'd0);
      tick();
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int n;
      int saw_done;
      rst    = 1'b1;
      start  = 1'b0;
      cancel = 1'b0;
      op_a   = '0;
      op_b   = '0;
      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      rst = 1'b0;
      tick();

      // 3*5 with cycle-by-cycle operand overrides
      op_a  = 16'd3;
      op_b  = 16'd5;
      start = 1'b1;
      #1;
      check("m35_accept_stall", 32'(stall), 32'd1);
      tick();
      start = 1'b0;
      check("m35_r1", {ovr_en, busy, ovr_ALUop, 12'h0, ovr_Ain}, {1'b1, 1'b1, 2'b00, 12'h0, 16'd0});
      check("m35_r1_bin", 32'(ovr_Bin), 32'd3);
      tick();
      check("m35_r2_ain", 32'(ovr_Ain), 32'd3);
      check("m35_r2_bin", 32'(ovr_Bin), 32'd6);
      tick();
      check("m35_r3_ain", 32'(ovr_Ain), 32'd3);
      check("m35_r3_bin", 32'(ovr_Bin), 32'd12);
      check("m35_r3_busy", 32'(busy), 32'd1);
      tick();
      check("m35_done", 32'(done), 32'd1);
      check("m35_result", 32'(result), 32'h000F);
      check("m35_done_stall", 32'(stall), 32'd0);
      check("m35_done_ovr", {ovr_en, busy, ovr_Ain, ovr_Bin[13:0]}, 32'd0);
      tick();
      check("m35_idle_done", 32'(done), 32'd0);

      // async reset in the middle of a long run
      op_a  = 16'hFFFF;
      op_b  = 16'hFFFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("arst_outs", {busy, stall, done, ovr_en}, 32'd0);
      check("arst_ovr", {ovr_Ain, ovr_Bin}, 32'd0);
      check("arst_result", 32'(result), 32'd0);
      tick();
      rst = 1'b0;
      saw_done = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done || busy) saw_done = 1;
      end
      check("arst_no_done", 32'(saw_done), 32'd0);

      mul_once("zero",  16'h1234, 16'h0000, 16'h0000, 1);
      mul_once("wrap",  16'h0100, 16'h0100, 16'h0000, 9);
      mul_once("full",  16'hFFFF, 16'hFFFF, 16'h0001, 16);
      mul_once("msb",   16'h0003, 16'h8000, 16'h8000, 16);

      // cancel on the 5th RUN cycle while start stays high
      op_a  = 16'hFFFF;
      op_b  = 16'hFFFF;
      start = 1'b1;
      tick();
      saw_done = 0;
      for (int i = 0; i < 4; i++) begin
         if (done) saw_done = 1;
         tick();
      end
      check("cxl_r5_busy", 32'(busy), 32'd1);
      cancel = 1'b1;
      tick();
      if (done) saw_done = 1;
      check("cxl_idle", {busy, ovr_en, stall, done}, 32'd0);
      check("cxl_result", 32'(result), 32'h8000);
      check("cxl_no_done", 32'(saw_done), 32'd0);

      // held start accepted once cancel drops, then back-to-back 7*9, 2*2
      cancel = 1'b0;
      op_a   = 16'd7;
      op_b   = 16'd9;
      #1;
      check("b2b_accept_stall", 32'(stall), 32'd1);
      tick();
      count_run(n);
      check("b2b1_run_cycles", 32'(n), 32'd4);
      check("b2b1_done", 32'(done), 32'd1);
      check("b2b1_result", 32'(result), 32'h003F);
      op_a = 16'd2;
      op_b = 16'd2;
      tick();
      check("b2b_gap_idle", {done, busy}, 32'd0);
      check("b2b_gap_stall", 32'(stall), 32'd1);
      tick();
      check("b2b2_busy", 32'(busy), 32'd1);
      start = 1'b0;
      count_run(n);
      check("b2b2_run_cycles", 32'(n), 32'd2);
      check("b2b2_done", 32'(done), 32'd1);
      check("b2b2_result", 32'(result), 32'h0004);
      tick();
      check("b2b2_hold", 32'(result), 32'h0004);
      check("b2b2_idle", {done, busy, stall}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
